// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcodes, state encoding and decode helper for the RV M-extension unit
package mdu_pkg;
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction
endpackage

// File: rtl/mdu_signfix.sv
// mdu_signfix: conditional two's-complement negation of a W-bit value
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] res
);
  assign res = negate ? -value : value;
endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative multiply/divide unit for RV M; shift-add multiply, restoring divide
module riscv_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int K  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(K);
  state_t state, state_n;
  logic [2:0] op;
  logic sa, sb;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] opa, hi, lo, hi_n, lo_n;
  logic [XLEN:0] r, s;
  logic [2*XLEN-1:0] fix0;
  logic [XLEN-1:0] fix1, res_fix, res_spec;
  logic sgn_a, sgn_b, na, nb, div_zero, div_ovf, mul_zero, special, accept, in_fix;
  assign sgn_a    = ~(funct3[0] & (funct3[1] | funct3[2]));
  assign sgn_b    = sgn_a & (funct3 != MDU_MULHSU);
  assign na       = sgn_a & srca[XLEN-1];
  assign nb       = sgn_b & srcb[XLEN-1];
  assign div_zero = is_div(funct3) & (srcb == '0);
  assign div_ovf  = is_div(funct3) & ~funct3[0] & (srca == {1'b1, {(XLEN-1){1'b0}}}) & (&srcb);
  assign mul_zero = ~is_div(funct3) & ((srca == '0) | (srcb == '0));
  assign special  = div_zero | div_ovf | mul_zero;
  assign res_spec = div_zero ? (funct3[1] ? srca : '1) : div_ovf ? (funct3[1] ? '0 : srca) : '0;
  assign accept   = (state == IDLE) & start & ~flush;
  assign in_fix   = state == FIX;
  // The same two negators take operand magnitudes in IDLE and correct result signs in FIX
  mdu_signfix #(.W(2*XLEN)) u_fix_wide (
    .value  (in_fix ? {hi, lo} : {{XLEN{1'b0}}, srca}),
    .negate (in_fix ? sa ^ sb : na),
    .res    (fix0)
  );
  mdu_signfix #(.W(XLEN)) u_fix_narrow (
    .value  (in_fix ? hi : srcb),
    .negate (in_fix ? sa : nb),
    .res    (fix1)
  );
  assign res_fix = op[2] ? (op[1] ? fix1 : fix0[XLEN-1:0])
                         : (op == MDU_MUL ? fix0[XLEN-1:0] : fix0[2*XLEN-1:XLEN]);
  // hi is the product high half / partial remainder; lo the multiplier / dividend-quotient
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    r = '0;
    s = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div(op)) begin
        r = {hi_n, lo_n[XLEN-1]};
        lo_n = {lo_n[XLEN-2:0], r >= {1'b0, opa}};
        r = r >= {1'b0, opa} ? r - {1'b0, opa} : r;
        hi_n = r[XLEN-1:0];
      end else begin
        s = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opa} : '0);
        lo_n = {s[0], lo_n[XLEN-1:1]};
        hi_n = s[XLEN:1];
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = flush ? IDLE
            : state == IDLE ? (start ? (special ? DONE : CALC) : IDLE)
            : state == CALC ? (cnt == CW'(K-1) ? FIX : CALC)
            : state == FIX  ? DONE : IDLE;
    ready = state == IDLE;
    busy  = state != IDLE;
    done  = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      cnt <= '0;
      opa <= '0;
      hi <= '0;
      lo <= '0;
      result <= '0;
    end else if (accept) begin
      op <= funct3;
      sa <= na;
      sb <= nb;
      cnt <= '0;
      hi <= '0;
      opa <= is_div(funct3) ? fix1 : fix0[XLEN-1:0];
      lo <= is_div(funct3) ? fix0[XLEN-1:0] : fix1;
      if (special) result <= res_spec;
    end else if (state == CALC) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 1'b1;
    end else if (in_fix && !flush) result <= res_fix;
endmodule

// File: doc/riscv_mdu.md
Name: riscv_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit for the RV M extension (funct7 = 0000001). It sits beside the single-cycle ALU in the execute stage.
- It decodes funct3 into one of eight M operations and computes the result iteratively.
- A start/done handshake lets the controller stall the datapath while the unit is busy.
- It generalises the ALU decode path to XLEN-wide operands, selectable radix, and sequential execution with early termination.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; legal values 1, 2, 4; must divide XLEN

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a new operation; sampled only when ready=1
- funct3  input  3  M opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srca  input  XLEN  rs1 operand (multiplicand/dividend)
- srcb  input  XLEN  rs2 operand (multiplier/divisor)
- flush  input  1  abort the operation in flight
- ready  output  1  unit idle, can accept start
- busy  output  1  operation in flight (inverse of ready)
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  XLEN  operation result; held until the next accepted start

Behaviour:
- Reset values:
  - state = IDLE, ready = 1, busy = 0, done = 0, result = 0
  - internal accumulators, counter, latched funct3 = 0
- States:
  - IDLE: ready = 1. On start, latch funct3, latch operand signs and take absolute values where the op is signed, clear the counter, then go to CALC. Special cases go to DONE instead.
  - CALC: each cycle, BITS_PER_CYCLE shift-add (multiply) or restoring-subtract (divide) steps. Counter increments by 1. After XLEN/BITS_PER_CYCLE iterations, go to FIX.
  - FIX: one cycle. Apply sign correction:
    - product negated if signs differ (MULH; MULHSU uses srca sign only)
    - quotient negated if signs differ
    - remainder takes the dividend sign
    - select the low or high XLEN bits of the 2*XLEN product
    - register result, go to DONE.
  - DONE: done = 1 for exactly one cycle, result valid; go to IDLE.
- Latency:
  - Start accepted at edge N: done high during cycle N + XLEN/BITS_PER_CYCLE + 2.
  - XLEN = 32, BPC = 1: done in cycle N+34.
- Special cases, detected in IDLE; the unit skips CALC/FIX and done is high in cycle N+1:
  - Divide by zero (srcb = 0): DIV/DIVU result = all ones; REM/REMU result = srca.
  - Signed overflow (DIV/REM, srca = 2^(XLEN-1), srcb = all ones): DIV result = srca; REM result = 0.
  - MUL* with either operand 0: result = 0.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: srca signed, srcb unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - All arithmetic is modulo 2^XLEN on the selected half.
- Handshake:
  - start while busy = 1 is ignored; no queuing.
  - start in the same cycle as done: ignored; ready is 0 in DONE.
- Flush:
  - Any state other than IDLE goes to IDLE at the next edge.
  - done is not asserted; result keeps its previous value.
  - flush and start together in IDLE: flush wins, start is dropped.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Undefined funct3 is impossible (3 bits, fully decoded); no X outputs are permitted.

Decomposition:
- Package mdu_pkg:
  - funct3 localparams (MDU_MUL ... MDU_REMU)
  - state enum typedef {IDLE, CALC, FIX, DONE}
  - helper function is_div(funct3) = funct3[2]
- Sub-module mdu_signfix:
  - Purely combinational; used twice.
  - Inputs: value, negate flag. Output: conditionally negated value.
  - Handles operand absolute-value prep in IDLE and result correction in FIX.
- Top-level holds the FSM, counter and the iterative datapath.

Test Plan (XLEN = 32, BITS_PER_CYCLE = 1 unless stated):
- MUL srca = 7, srcb = 0xFFFFFFFD (-3) -> done at N+34, result = 0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14. REM 0xFFFFFFF9 (-7) % 2 -> 0xFFFFFFFF. DIV -7 / 2 -> 0xFFFFFFFD. Repeat all with BITS_PER_CYCLE = 4: done at N+10.
- DIV by 0 -> 0xFFFFFFFF at N+1. REMU 5 % 0 -> 5 at N+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and the REM variant -> 0, both at N+1.
- Start DIVU; pulse start with new operands at N+5 -> ignored, the original result is delivered. Pulse flush at N+10 -> ready at N+11, no done, result unchanged.
- Assert reset at N+12 of a MUL -> ready = 1, done = 0, result = 0 immediately. A fresh op after deassertion completes with the correct value.
